uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the UART transmit FIFO write port (`tx_fifo_data` / `tx_fifo_write` / `tx_fifo_full`) between several on-chip byte-stream sources. Example sources are the register-access FSM's readback path and the TDC measurement streamer. Each granted packet is written to the FIFO uninterrupted and is prefixed with a source-ID header byte, so the host can demultiplex the serial stream. The block sits between the sources and the transmit FIFO, in place of a direct FSM-to-FIFO connection.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `MAXLEN`, default 64: maximum data bytes per packet, 1..255.
- `HDRBASE`, default 8'hA0: header byte base; the header is `HDRBASE | id`.

Ports (clock and reset first):
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `src_data`  in  8*NREQ  byte from requester i on bits [8i+7:8i].
- `src_valid`  in  NREQ  requester i presents a byte.
- `src_last`  in  NREQ  the presented byte is the last of its packet.
- `src_ready`  out  NREQ  byte accepted from requester i this cycle.
- `tx_fifo_data`  out  8  byte to the transmit FIFO.
- `tx_fifo_write`  out  1  write strobe to the transmit FIFO.
- `tx_fifo_full`  in  1  FIFO full; no write may be issued while high.
- `grant`  out  NREQ  one-hot owner of the FIFO port; 0 when idle.
- `busy`  out  1  a packet is in progress (state ≠ IDLE).
- `trunc_err`  out  1  one-cycle pulse when a packet is truncated at MAXLEN.

## Operation
- States: IDLE, HDR, DATA. Registers: `state`, `gid` (granted index), `rr` (round-robin pointer), `cnt` (8-bit data-byte counter).
- In IDLE:
  - If any `src_valid` is high, pick the first valid index scanning `rr, rr+1, … , NREQ-1, 0, …`, wrapping modulo NREQ.
  - Load `gid`, clear `cnt`, go to HDR.
  - No byte is accepted in IDLE.
- In HDR:
  - When `tx_fifo_full`=0, write `HDRBASE | gid` and go to DATA.
  - When full, hold in HDR.
- In DATA:
  - `src_ready[gid] = !tx_fifo_full`; all other `src_ready` bits are 0.
  - A byte transfers when `src_valid[gid] & src_ready[gid]`. That cycle: `tx_fifo_write`=1, `tx_fifo_data = src_data[gid]`, `cnt++`.
  - Transfer with `src_last[gid]`=1: go to IDLE, set `rr = (gid+1) mod NREQ`.
  - Transfer where `cnt` reaches MAXLEN and `src_last`=0: pulse `trunc_err`, go to IDLE, advance `rr` as above. The source's following bytes form a new packet with a new header.
  - Valid dropping low mid-packet: the grant is held; there is no timeout.
- `src_valid`/`src_data`/`src_last` of non-granted requesters are ignored. Those sources must hold their byte until ready.
- `tx_fifo_write`, `tx_fifo_data`, `src_ready` are combinational from state registers and inputs.
  - `tx_fifo_data` = 0 when not writing.
  - `tx_fifo_write` is never high while `tx_fifo_full`=1.
- `grant` = one-hot of `gid` in HDR/DATA, 0 in IDLE.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, gid=0, rr=0, cnt=0.
  - All outputs 0: `src_ready`, `tx_fifo_write`, `tx_fifo_data`, `grant`, `busy`, `trunc_err`.
  - Reset mid-packet abandons the packet immediately, with no further FIFO writes. Release is used synchronously by the implementation; the first arbitration happens on the second edge after deassertion at the earliest.
- Latency: valid seen in IDLE at edge k; header written during cycle k+1 (if not full); first data byte accepted at the earliest in cycle k+2.
- Throughput: 1 byte per cycle in DATA; packet overhead is 2 cycles (IDLE + HDR).
- Back-to-back packets from the same source: the IDLE cycle is always inserted, and other valid sources win by round robin.
- Simultaneous `src_last` and `cnt` reaching MAXLEN: treated as a normal end; no `trunc_err`.
- `tx_fifo_full` rising in DATA stalls the transfer in the same cycle, with no byte lost and `cnt` unchanged.
- `trunc_err` is high exactly in the cycle of the truncating transfer.

## Test plan
- **Single packet.** NREQ=2; src0 sends 0x11, 0x22, 0x33 (last on 0x33), FIFO never full.
  - FIFO receives A0, 11, 22, 33 on consecutive cycles.
  - `grant`=01 for 4 cycles; `busy` drops the cycle after 0x33.
- **Contention.** src0 and src1 both valid from reset with 2-byte packets, repeated.
  - FIFO order: A0 x x A1 y y A0 x x A1 …
  - No interleaving of bytes from different sources.
- **Back-pressure.** Assert `tx_fifo_full` for 3 cycles during the HDR state, then for 2 cycles mid-DATA.
  - `tx_fifo_write`=0 and `src_ready`=0 while full.
  - Byte stream unchanged, no duplicates or drops.
- **Truncation.** MAXLEN=4; src1 sends 6 bytes 01..06 with last on 06.
  - FIFO: A1 01 02 03 04 A1 05 06.
  - `trunc_err` pulses once, on byte 04.
- **Reset mid-packet.** Pull `reset` low during the second data byte.
  - All outputs 0 immediately.
  - After release, a new packet from src1 starts with header A1, round robin restarting at 0.
- **Idle source gap.** src0 drops `src_valid` for 5 cycles mid-packet while src1 is valid.
  - `grant` stays 01 and src1 is not served until src0's last byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level round-robin arbiter sharing the UART transmit FIFO write port
//   between NREQ byte-stream sources. Each granted packet goes to the FIFO
//   uninterrupted and is prefixed by a header byte HDRBASE | id, so the host
//   can demultiplex the serial stream.
// Ports:
//   sysclk, reset        clock; asynchronous active-low reset
//   src_data/valid/last  per-requester byte stream (byte i on [8i+7:8i])
//   src_ready            byte from requester i accepted this cycle
//   tx_fifo_data/write   FIFO write port; tx_fifo_full back-pressure input
//   grant                one-hot packet owner, 0 when idle
//   busy                 a packet is in progress
//   trunc_err            one-cycle pulse on a packet cut at MAXLEN bytes
module uart_tx_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          MAXLEN  = 64,
  parameter logic [7:0]  HDRBASE = 8'hA0
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [8*NREQ-1:0]   src_data,
  input  logic [NREQ-1:0]     src_valid,
  input  logic [NREQ-1:0]     src_last,
  output logic [NREQ-1:0]     src_ready,
  output logic [7:0]          tx_fifo_data,
  output logic                tx_fifo_write,
  input  logic                tx_fifo_full,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic                trunc_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [7:0]      cnt_q, cnt_d;
  // Reset release is taken synchronously: arbitration is held off until one
  // clean edge after deassertion has been seen.
  logic            run_q;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   gid_nxt;
  logic [7:0]      cnt_inc;
  logic [7:0]      hdr_byte;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  // Round-robin scan starting at rr_q, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign gid_nxt  = (gid_q == IW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
  assign cnt_inc  = cnt_q + 8'd1;
  assign hdr_byte = HDRBASE | {{(8 - IW){1'b0}}, gid_q};

  always_comb begin
    state_d       = state_q;
    gid_d         = gid_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    src_ready     = '0;
    tx_fifo_write = 1'b0;
    tx_fifo_data  = 8'h00;
    trunc_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && found) begin
          gid_d   = pick;
          cnt_d   = 8'd0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = hdr_byte;
          state_d       = DATA;
        end
      end
      DATA: begin
        src_ready[gid_q] = !tx_fifo_full;
        if (src_valid[gid_q] && !tx_fifo_full) begin
          tx_fifo_write = 1'b1;
          tx_fifo_data  = src_data[int'(gid_q)*8 +: 8];
          cnt_d         = cnt_inc;
          // A last byte landing exactly on MAXLEN is a normal end.
          if (src_last[gid_q]) begin
            state_d = IDLE;
            rr_d    = gid_nxt;
          end else if (cnt_inc == 8'(MAXLEN)) begin
            trunc_err = 1'b1;
            state_d   = IDLE;
            rr_d      = gid_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    grant = '0;
    if (busy) grant[gid_q] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ   = 2;
  localparam int MAXLEN = 4;

  logic                sysclk = 1'b0;
  logic                reset;
  logic [8*NREQ-1:0]   src_data;
  logic [NREQ-1:0]     src_valid;
  logic [NREQ-1:0]     src_last;
  logic [NREQ-1:0]     src_ready;
  logic [7:0]          tx_fifo_data;
  logic                tx_fifo_write;
  logic                tx_fifo_full;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                trunc_err;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN), .HDRBASE(8'hA0)) dut (
    .sysclk(sysclk), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ready(src_ready),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_write(tx_fifo_write),
    .tx_fifo_full(tx_fifo_full),
    .grant(grant), .busy(busy), .trunc_err(trunc_err)
  );

  int total = 0;
  int bad   = 0;

  // Source model: per-requester queue of {last, data}; scoreboard of FIFO bytes.
  logic [8:0] q_src [NREQ][$];
  logic [7:0] exp_q [$];
  bit         full_plan [$];
  int         pause [NREQ];

  logic [NREQ-1:0] s_ready, s_grant;
  logic            s_wr, s_busy, s_trunc;
  logic [7:0]      s_data;
  int              wr_cnt = 0;
  int              trunc_cnt = 0;
  logic [7:0]      trunc_byte = 8'h00;

  function automatic logic [8:0] ent(input bit l, input int d);
    return {l, 8'(d)};
  endfunction

  // One clock cycle: drive inputs after the edge, sample at the falling edge,
  // score FIFO writes, retire accepted source bytes.
  task automatic step();
    logic [8:0] hd;
    logic [7:0] e;
    tx_fifo_full = 1'b0;
    if (full_plan.size() > 0) tx_fifo_full = full_plan.pop_front();
    for (int i = 0; i < NREQ; i++) begin
      if (q_src[i].size() > 0 && pause[i] == 0) begin
        hd = q_src[i][0];
        src_valid[i] = 1'b1;
        src_data[8*i +: 8] = hd[7:0];
        src_last[i] = hd[8];
      end else begin
        src_valid[i] = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i] = 1'b0;
      end
    end
    @(negedge sysclk);
    s_wr = tx_fifo_write; s_data = tx_fifo_data; s_ready = src_ready;
    s_grant = grant; s_busy = busy; s_trunc = trunc_err;
    if (s_wr) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got write %h want none", s_data);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e) begin
          bad++;
          $display("FAIL sb_byte: got %h want %h", s_data, e);
        end
      end
    end else begin
      total++;
      if (s_data !== 8'h00) begin
        bad++;
        $display("FAIL data_idle: got %h want 00", s_data);
      end
    end
    if (tx_fifo_full) begin
      total++;
      if (s_wr !== 1'b0 || s_ready !== '0) begin
        bad++;
        $display("FAIL full_stall: got wr=%b ready=%b want 0/0", s_wr, s_ready);
      end
    end
    if (s_trunc) begin
      trunc_cnt++;
      trunc_byte = s_data;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (src_valid[i] && s_ready[i]) void'(q_src[i].pop_front());
      if (pause[i] > 0) pause[i]--;
    end
    @(posedge sysclk);
    #1;
  endtask

  task automatic run_until_done(input int budget, input string name);
    bit done;
    int pend;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      pend = exp_q.size();
      for (int i = 0; i < NREQ; i++) pend += q_src[i].size();
      done = (pend == 0) && !s_busy;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: got pending exp=%0d want 0", name, exp_q.size());
      exp_q.delete();
      foreach (q_src[i]) q_src[i].delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src_valid = '0; src_last = '0; src_data = '0; tx_fifo_full = 1'b0;
    exp_q.delete(); full_plan.delete();
    foreach (q_src[i]) q_src[i].delete();
    foreach (pause[i]) pause[i] = 0;
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    src_valid = '1; src_last = '0; src_data = 16'h5A5A; tx_fifo_full = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    total += 6;
    if (src_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", src_ready); end
    if (tx_fifo_write !== 1'b0) begin bad++; $display("FAIL rst_write: got %b want 0", tx_fifo_write); end
    if (tx_fifo_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", tx_fifo_data); end
    if (grant !== '0) begin bad++; $display("FAIL rst_grant: got %b want 0", grant); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (trunc_err !== 1'b0) begin bad++; $display("FAIL rst_trunc: got %b want 0", trunc_err); end
    src_valid = '0; src_data = '0;
    @(posedge sysclk);
    #1 reset = 1'b1;
    step(); step();
  endtask

  task automatic test_single_packet();
    int gcnt, first_wr, last_wr, n33, w0;
    gcnt = 0; first_wr = -1; last_wr = -1; n33 = -1; w0 = wr_cnt;
    q_src[0].push_back(ent(0, 8'h11));
    q_src[0].push_back(ent(0, 8'h22));
    q_src[0].push_back(ent(1, 8'h33));
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_grant == 2'b01) gcnt++;
      if (s_wr) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (s_wr && s_data == 8'h33) n33 = c;
      if (n33 >= 0 && c == n33 + 1) begin
        total++;
        if (s_busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b want 0", s_busy); end
      end
    end
    total += 4;
    if (gcnt != 4) begin bad++; $display("FAIL single_grant_cycles: got %0d want 4", gcnt); end
    if (first_wr != 1) begin bad++; $display("FAIL single_latency: got %0d want 1", first_wr); end
    if (last_wr - first_wr != 3 || wr_cnt - w0 != 4) begin
      bad++; $display("FAIL single_contig: got span=%0d writes=%0d want 3/4", last_wr - first_wr, wr_cnt - w0);
    end
    if (exp_q.size() != 0 || n33 < 0) begin
      bad++; $display("FAIL single_done: got pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      q_src[0].push_back(ent(0, 8'h10 + 2*p)); q_src[0].push_back(ent(1, 8'h11 + 2*p));
      q_src[1].push_back(ent(0, 8'h20 + 2*p)); q_src[1].push_back(ent(1, 8'h21 + 2*p));
      exp_q.push_back(8'hA0); exp_q.push_back(8'(8'h10 + 2*p)); exp_q.push_back(8'(8'h11 + 2*p));
      exp_q.push_back(8'hA1); exp_q.push_back(8'(8'h20 + 2*p)); exp_q.push_back(8'(8'h21 + 2*p));
    end
    run_until_done(80, "contention");
  endtask

  task automatic test_backpressure();
    int w0;
    bit plan [9];
    plan = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
    w0 = wr_cnt;
    foreach (plan[i]) full_plan.push_back(plan[i]);
    for (int k = 0; k < 4; k++) begin
      q_src[0].push_back(ent(k == 3, 8'h31 + k));
      exp_q.push_back(8'(8'h31 + k));
    end
    exp_q.push_front(8'hA0);
    run_until_done(40, "backpressure");
    total++;
    if (wr_cnt - w0 != 5) begin bad++; $display("FAIL bp_writes: got %0d want 5", wr_cnt - w0); end
  endtask

  task automatic test_truncation();
    int t0;
    t0 = trunc_cnt;
    for (int k = 1; k <= 6; k++) q_src[1].push_back(ent(k == 6, k));
    exp_q.push_back(8'hA1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'hA1); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    run_until_done(40, "trunc");
    total += 2;
    if (trunc_cnt - t0 != 1) begin bad++; $display("FAIL trunc_count: got %0d want 1", trunc_cnt - t0); end
    if (trunc_byte !== 8'h04) begin bad++; $display("FAIL trunc_byte: got %h want 04", trunc_byte); end
    // Last byte coinciding with MAXLEN ends normally.
    t0 = trunc_cnt;
    exp_q.push_back(8'hA0);
    for (int k = 0; k < 4; k++) begin
      q_src[0].push_back(ent(k == 3, 8'h61 + k));
      exp_q.push_back(8'(8'h61 + k));
    end
    run_until_done(40, "exact_max");
    total++;
    if (trunc_cnt - t0 != 0) begin bad++; $display("FAIL exact_max_trunc: got %0d want 0", trunc_cnt - t0); end
  endtask

  task automatic test_idle_gap();
    bit seen;
    do_reset();
    q_src[0].push_back(ent(0, 8'h41)); q_src[0].push_back(ent(0, 8'h42));
    q_src[0].push_back(ent(1, 8'h43));
    q_src[1].push_back(ent(1, 8'h51));
    exp_q.push_back(8'hA0); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h43); exp_q.push_back(8'hA1); exp_q.push_back(8'h51);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      seen = s_wr && (s_data == 8'h41);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL gap_start: got no 41 want 41"); end
    pause[0] = 5;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (s_grant !== 2'b01 || s_ready[1] !== 1'b0 || s_wr !== 1'b0) begin
        bad++; $display("FAIL gap_hold: got grant=%b ready=%b wr=%b want 01/0/0", s_grant, s_ready, s_wr);
      end
    end
    run_until_done(40, "gap");
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    q_src[0].push_back(ent(1, 8'h71));
    q_src[0].push_back(ent(0, 8'h11)); q_src[0].push_back(ent(0, 8'h22));
    q_src[0].push_back(ent(1, 8'h33));
    exp_q.push_back(8'hA0); exp_q.push_back(8'h71);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = s_wr && (s_data == 8'h11);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rmid_start: got no 11 want 11"); end
    // Second data byte is on the bus; pull reset in the middle of the cycle.
    src_valid = 2'b01; src_data = 16'h0022; src_last = '0; tx_fifo_full = 1'b0;
    #2 reset = 1'b0;
    #1;
    total += 5;
    if (tx_fifo_write !== 1'b0) begin bad++; $display("FAIL rmid_write: got %b want 0", tx_fifo_write); end
    if (tx_fifo_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", tx_fifo_data); end
    if (src_ready !== '0) begin bad++; $display("FAIL rmid_ready: got %b want 0", src_ready); end
    if (grant !== '0) begin bad++; $display("FAIL rmid_grant: got %b want 0", grant); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++;
    if (exp_q.size() != 2) begin bad++; $display("FAIL rmid_abandon: got pending=%0d want 2", exp_q.size()); end
    do_reset();
    // rr restarts at 0, so src0 wins the first arbitration against src1.
    q_src[1].push_back(ent(1, 8'h55));
    q_src[0].push_back(ent(1, 8'h66));
    exp_q.push_back(8'hA0); exp_q.push_back(8'h66);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h55);
    step();
    total++;
    if (s_busy !== 1'b0) begin bad++; $display("FAIL rmid_sync1: got busy=%b want 0", s_busy); end
    step();
    total++;
    if (s_busy !== 1'b0) begin bad++; $display("FAIL rmid_sync2: got busy=%b want 0", s_busy); end
    step();
    total++;
    if (s_grant !== 2'b01 || s_wr !== 1'b1) begin
      bad++; $display("FAIL rmid_restart: got grant=%b wr=%b want 01/1", s_grant, s_wr);
    end
    run_until_done(40, "rmid_after");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_truncation();
    test_idle_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
